// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer ones-digit controller.
package timer_pkg;

    localparam int unsigned DIGIT_W      = 4;
    localparam int unsigned ONES_MAX_DEF = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Preset values above the digit's maximum clamp to the maximum.
    function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] d,
                                                     input logic [DIGIT_W-1:0] max);
        return (d > max) ? max : d;
    endfunction

endpackage

// File: rtl/mod10_down.sv
// Ones-digit datapath: saturating preset load and decrement that wraps 0 -> MAX.
module mod10_down
    import timer_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = DIGIT_W'(ONES_MAX_DEF)
) (
    input  logic               clock,
    input  logic               clrn,
    input  logic               load,
    input  logic [DIGIT_W-1:0] data,
    input  logic               dec,
    output logic [DIGIT_W-1:0] value,
    output logic               zero
);

    always_ff @(posedge clock) begin
        if (!clrn) begin
            value <= '0;
        end else if (load) begin
            value <= sat_digit(data, MAX);
        end else if (dec) begin
            value <= (value == '0) ? MAX : value - DIGIT_W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/timer_ones_ctrl.sv
// Ones-digit countdown controller: IDLE/RUN/PAUSE/DONE FSM, alarm and tens-stage strobes.
module timer_ones_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned ONES_MAX = ONES_MAX_DEF
) (
    input  logic               clock,
    input  logic               clrn,
    input  logic [DIGIT_W-1:0] data,
    input  logic               loadn,
    input  logic               start,
    input  logic               stop,
    input  logic               tick,
    input  logic               tens_tc,
    output logic [DIGIT_W-1:0] ones,
    output logic               ones_tc,
    output logic               tens_enable,
    output logic               tens_loadn,
    output logic               running,
    output logic               alarm
);

    localparam logic [DIGIT_W-1:0] MaxV = DIGIT_W'(ONES_MAX);

    state_e state;
    logic   load;
    logic   dec;
    logic   zero;
    logic   at_end;
    logic   last_step;

    always_comb begin
        load      = !loadn;
        at_end    = zero && tens_tc;
        // The decrement that lands on 00 ends the countdown at the same edge.
        last_step = (ones == DIGIT_W'(1)) && tens_tc;
        dec       = (state == RUN) && loadn && !stop && tick && !at_end;
    end

    mod10_down #(
        .MAX(MaxV)
    ) u_digit (
        .clock(clock),
        .clrn (clrn),
        .load (load),
        .data (data),
        .dec  (dec),
        .value(ones),
        .zero (zero)
    );

    always_ff @(posedge clock) begin
        if (!clrn) begin
            state       <= IDLE;
            tens_enable <= 1'b0;
            tens_loadn  <= 1'b1;
            alarm       <= 1'b0;
        end else begin
            tens_loadn  <= loadn;
            tens_enable <= 1'b0;
            if (load) begin
                state <= IDLE;
                alarm <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!stop && start) begin
                            if (at_end) begin
                                state <= DONE;
                                alarm <= 1'b1;
                            end else begin
                                state <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            state <= PAUSE;
                        end else if (at_end) begin
                            state <= DONE;
                            alarm <= 1'b1;
                        end else if (tick) begin
                            if (zero) begin
                                tens_enable <= 1'b1;
                            end else if (last_step) begin
                                state <= DONE;
                                alarm <= 1'b1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (!stop && start) begin
                            state <= RUN;
                        end
                    end
                    DONE: begin
                        alarm <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign ones_tc = (ones == '0);
    assign running = (state == RUN);

endmodule

// File: tb/tb_timer_ones_ctrl.sv
// Randomised and directed bench for timer_ones_ctrl against a rule-level reference model.
module tb_timer_ones_ctrl;

    logic       clock = 1'b0;
    logic       clrn;
    logic [3:0] data;
    logic       loadn;
    logic       start;
    logic       stop;
    logic       tick;
    logic       tens_tc;
    logic [3:0] ones;
    logic       ones_tc;
    logic       tens_enable;
    logic       tens_loadn;
    logic       running;
    logic       alarm;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, kept as plain integers.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_mode;
    int m_ones;
    int m_alarm;
    int m_ten;
    int m_tl;

    always #5 clock = ~clock;

    timer_ones_ctrl dut (
        .clock      (clock),
        .clrn       (clrn),
        .data       (data),
        .loadn      (loadn),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .tens_tc    (tens_tc),
        .ones       (ones),
        .ones_tc    (ones_tc),
        .tens_enable(tens_enable),
        .tens_loadn (tens_loadn),
        .running    (running),
        .alarm      (alarm)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic finish_countdown();
        m_mode  = M_DONE;
        m_alarm = 1;
    endtask

    // One clock edge of the specified behaviour, applied in priority order.
    task automatic model_edge();
        int pulse;
        pulse = 0;
        if (!clrn) begin
            m_mode = M_IDLE; m_ones = 0; m_alarm = 0; m_ten = 0; m_tl = 1;
            return;
        end
        m_tl = int'(loadn);
        if (!loadn) begin
            m_ones  = (int'(data) > 9) ? 9 : int'(data);
            m_alarm = 0;
            m_mode  = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (start && !stop) begin
                if (m_ones == 0 && tens_tc) finish_countdown();
                else m_mode = M_RUN;
            end
        end else if (m_mode == M_RUN) begin
            if (stop) begin
                m_mode = M_PAUSE;
            end else if (m_ones == 0 && tens_tc) begin
                finish_countdown();
            end else if (tick) begin
                if (m_ones > 0) begin
                    m_ones = m_ones - 1;
                    if (m_ones == 0 && tens_tc) finish_countdown();
                end else begin
                    m_ones = 9;
                    pulse  = 1;
                end
            end
        end else if (m_mode == M_PAUSE) begin
            if (start && !stop) m_mode = M_RUN;
        end
        m_ten = pulse;
    endtask

    task automatic cyc(input logic c, input logic l, input logic sa, input logic so,
                       input logic t, input logic tc, input logic [3:0] d);
        clrn = c; loadn = l; start = sa; stop = so; tick = t; tens_tc = tc; data = d;
        @(posedge clock);
        model_edge();
        #1;
        check_eq("ones", 32'(ones), 32'(m_ones));
        check_eq("ones_tc", 32'(ones_tc), 32'(m_ones == 0));
        check_eq("tens_enable", 32'(tens_enable), 32'(m_ten));
        check_eq("tens_loadn", 32'(tens_loadn), 32'(m_tl));
        check_eq("running", 32'(running), 32'(m_mode == M_RUN));
        check_eq("alarm", 32'(alarm), 32'(m_alarm));
        check_eq("strobe_vs_loadn", 32'(tens_enable & ~tens_loadn), 32'(0));
    endtask

    initial begin
        m_mode = M_IDLE; m_ones = 0; m_alarm = 0; m_ten = 0; m_tl = 1;

        // Reset state
        cyc(0, 1, 1, 0, 1, 0, 4'd7);
        check_eq("rst_ones", 32'(ones), 0);
        check_eq("rst_tens_loadn", 32'(tens_loadn), 1);

        // Load 3 then count to 00 with tens at zero
        cyc(1, 0, 0, 0, 0, 1, 4'd3);
        check_eq("ld3_ones", 32'(ones), 3);
        cyc(1, 1, 1, 0, 0, 1, 4'd0);
        check_eq("ld3_run", 32'(running), 1);
        cyc(1, 1, 0, 0, 1, 1, 4'd0);
        check_eq("ld3_t1", 32'(ones), 2);
        cyc(1, 1, 0, 0, 1, 1, 4'd0);
        check_eq("ld3_t2", 32'(ones), 1);
        cyc(1, 1, 0, 0, 1, 1, 4'd0);
        check_eq("ld3_t3", 32'(ones), 0);
        check_eq("ld3_alarm", 32'(alarm), 1);
        check_eq("ld3_done", 32'(running), 0);

        // Wrap with tens non-zero
        cyc(1, 0, 0, 0, 0, 0, 4'd0);
        cyc(1, 1, 1, 0, 0, 0, 4'd0);
        cyc(1, 1, 0, 0, 1, 0, 4'd0);
        check_eq("wrap_ones", 32'(ones), 9);
        check_eq("wrap_en", 32'(tens_enable), 1);
        cyc(1, 1, 0, 0, 0, 0, 4'd0);
        check_eq("wrap_en_off", 32'(tens_enable), 0);

        // Pause: stop beats a simultaneous tick
        cyc(1, 0, 0, 0, 0, 0, 4'd5);
        cyc(1, 1, 1, 0, 0, 0, 4'd0);
        cyc(1, 1, 0, 1, 1, 0, 4'd0);
        check_eq("pause_ones", 32'(ones), 5);
        check_eq("pause_run", 32'(running), 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 1, 0, 4'd0);
        check_eq("pause_hold", 32'(ones), 5);
        cyc(1, 1, 1, 0, 0, 0, 4'd0);
        check_eq("resume_run", 32'(running), 1);
        cyc(1, 1, 0, 0, 1, 0, 4'd0);
        check_eq("resume_tick", 32'(ones), 4);

        // Saturating load and reload out of DONE
        cyc(1, 0, 0, 0, 0, 1, 4'd12);
        check_eq("sat_ones", 32'(ones), 9);
        check_eq("sat_tl_low", 32'(tens_loadn), 0);
        cyc(1, 0, 0, 0, 0, 1, 4'd1);
        cyc(1, 1, 1, 0, 0, 1, 4'd0);
        check_eq("sat_tl_high", 32'(tens_loadn), 1);
        cyc(1, 1, 0, 0, 1, 1, 4'd0);
        check_eq("done_alarm", 32'(alarm), 1);
        cyc(1, 1, 1, 0, 1, 1, 4'd0);
        check_eq("done_hold", 32'(ones), 0);
        cyc(1, 0, 0, 0, 0, 1, 4'd6);
        check_eq("reload_alarm", 32'(alarm), 0);
        check_eq("reload_ones", 32'(ones), 6);

        // Reset on the same edge as a wrapping tick
        cyc(1, 0, 0, 0, 0, 0, 4'd0);
        cyc(1, 1, 1, 0, 0, 0, 4'd0);
        cyc(0, 1, 0, 0, 1, 0, 4'd0);
        check_eq("rst_mid_ones", 32'(ones), 0);
        check_eq("rst_mid_en", 32'(tens_enable), 0);
        check_eq("rst_mid_run", 32'(running), 0);

        // Start at 00 goes straight to DONE
        cyc(1, 1, 1, 0, 0, 1, 4'd0);
        check_eq("zero_start_alarm", 32'(alarm), 1);
        check_eq("zero_start_run", 32'(running), 0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(63, 0) != 0), ($urandom_range(15, 0) != 0),
                ($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0),
                ($urandom_range(1, 0) == 0), ($urandom_range(2, 0) != 0),
                4'($urandom_range(15, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_ones_ctrl.md
TIMER_ONES_CTRL -- requirements
Module: timer_ones_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset: the clock is named clock, and the reset is named clrn, synchronous and active-low.
REQ-002 Parameter ONES_MAX, default 9, SHALL set the preset/wrap value of the ones digit.
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 clrn  in  1  synchronous active-low reset, sampled on the rising edge of clock.
REQ-005 data  in  4  ones-digit preset value.
REQ-006 loadn  in  1  active-low load request; the same signal is forwarded to the tens stage.
REQ-007 start  in  1  level, request counting.
REQ-008 stop  in  1  level, request pause.
REQ-009 tick  in  1  one-cycle count strobe (1 Hz base).
REQ-010 tens_tc  in  1  high when the downstream mod-6 tens digit equals 0.
REQ-011 ones  out  4  current ones digit, 0..ONES_MAX.
REQ-012 ones_tc  out  1  combinational, high when ones==0.
REQ-013 tens_enable  out  1  registered one-cycle decrement strobe to the tens stage.
REQ-014 tens_loadn  out  1  registered copy of loadn.
REQ-015 running  out  1  high in state RUN.
REQ-016 alarm  out  1  sticky indication that countdown reached 00.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN, PAUSE and DONE.
REQ-018 Per-cycle priority SHALL be: clrn > loadn > stop > start > tick.
REQ-019 loadn low in any state SHALL, at that edge: set ones=min(data,ONES_MAX), clear alarm, and enter IDLE.
REQ-020 IDLE with start high SHALL enter DONE if ones==0 and tens_tc==1; otherwise it SHALL enter RUN.
REQ-021 RUN with stop high SHALL enter PAUSE, and a tick in the same cycle SHALL be ignored.
REQ-022 RUN with tick high and ones>0 SHALL decrement ones by 1; if the new ones==0 and tens_tc==1, the block SHALL enter DONE and set alarm at the same edge.
REQ-023 RUN with tick high, ones==0 and tens_tc==0 SHALL set ones=ONES_MAX and drive tens_enable=1 for exactly the following cycle.
REQ-024 RUN with ones==0 and tens_tc==1, reached by any path, SHALL enter DONE on the next edge without decrementing.
REQ-025 PAUSE SHALL ignore tick, and start high with stop low SHALL enter RUN.
REQ-026 DONE SHALL hold ones=0 and alarm=1, and SHALL ignore start, stop and tick; only loadn low or clrn low exits it.
REQ-027 tens_enable SHALL never be high outside the cycle defined in REQ-023, and SHALL never be high in the same cycle as tens_loadn low.
REQ-028 tens_loadn SHALL equal loadn delayed by one cycle.
REQ-029 data values 10..15 SHALL load as ONES_MAX.

Reset
REQ-030 On a clock edge with clrn low, the block SHALL set: state=IDLE, ones=0, tens_enable=0, tens_loadn=1, alarm=0, running=0.
REQ-031 Reset asserted mid-RUN SHALL take effect at that edge, and tens_enable SHALL be 0 on the following cycle.
REQ-032 The block SHALL have no asynchronous reset path.

Structure
REQ-033 Package timer_pkg SHALL hold the state enum (IDLE, RUN, PAUSE, DONE) and the constants DIGIT_W=4 and ONES_MAX_DEF=9.
REQ-034 The design SHALL contain one sub-module, mod10_down: a load/decrement/wrap datapath for the ones digit; the FSM, alarm and tens strobes SHALL stay in the top level.

Verification
REQ-035 Load then start: data=3, loadn pulse, start, tens_tc=1, 3 ticks -> ones 3,2,1,0; DONE and alarm=1 at the third tick edge; tens_enable never asserted.
REQ-036 Wrap: ones=0, tens_tc=0, RUN, tick -> ones=9 next cycle; tens_enable high for exactly 1 cycle.
REQ-037 Pause: RUN with ones=5; stop and tick in the same cycle -> ones stays 5 and state is PAUSE; 3 further ticks ignored; start -> RUN; next tick -> ones=4.
REQ-038 Saturation and reload: data=12 with loadn low -> ones=9; loadn low while in DONE -> alarm=0 and state IDLE; tens_loadn low exactly one cycle after loadn.
REQ-039 Reset mid-run: clrn low on the same edge as a wrapping tick -> ones=0, state IDLE, tens_enable=0.
REQ-040 Start at zero: ones=0, tens_tc=1, start -> DONE next edge, alarm=1, running never high.
